// File: rtl/nr_mem_pkg.sv
// ---------------------------------------------------------------------------
// nr_mem_pkg
// Shared definitions for the memory access unit: default bus widths and the
// FSM state encoding. The VRD state is only reached when the unit is built
// with NR_MAU_WRITE_VERIFY_EN defined; its encoding is reserved either way so
// that state values stay identical across both builds.
// ---------------------------------------------------------------------------
package nr_mem_pkg;

  localparam int NR_ADDR_W = 8;
  localparam int NR_DATA_W = 8;

  typedef logic [2:0] nr_state_t;

  localparam nr_state_t ST_IDLE = 3'd0;
  localparam nr_state_t ST_WR   = 3'd1;
  localparam nr_state_t ST_RD   = 3'd2;
  localparam nr_state_t ST_VRD  = 3'd3;
  localparam nr_state_t ST_RSP  = 3'd4;

endpackage

// File: rtl/nr_mem_access_unit.sv
// ---------------------------------------------------------------------------
// nr_mem_access_unit
// Bridges a valid/ready request/response interface from a core to a simple
// clock-gated memory (in0/adrIn0/adrOut0/canWrt/canRd/m_out0). One request
// is handled at a time: IDLE -> WR or RD -> RSP -> IDLE.
//
// Configuration macro: NR_MAU_WRITE_VERIFY_EN
//   When defined, every write is followed by a VRD read-back cycle and
//   rsp_err reports whether the memory returned something other than the
//   written data. When undefined, VRD is never entered and rsp_err is 0.
//
// Ports
//   clk, clr          : clock, synchronous active-low reset
//   req_valid/ready   : request handshake; req_wr selects write (1) or read
//   req_adr, req_data : request address and write data
//   rsp_valid/ready   : response handshake
//   rsp_data          : read data, or the written data on a write
//   rsp_err           : write-verify mismatch
//   busy              : unit is not in IDLE
//   mem_*             : memory-side buses and strobes
// ---------------------------------------------------------------------------
module nr_mem_access_unit
  import nr_mem_pkg::*;
#(
  parameter int ADDR_W = NR_ADDR_W,
  parameter int DATA_W = NR_DATA_W
) (
  input  logic              clk,
  input  logic              clr,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_data,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,

  output logic [DATA_W-1:0] mem_in0,
  output logic [ADDR_W-1:0] mem_adrIn0,
  output logic [ADDR_W-1:0] mem_adrOut0,
  output logic              mem_canWrt,
  output logic              mem_canRd,
  input  logic [DATA_W-1:0] mem_out0
);

  nr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] mem_in0_q, mem_in0_d;
  logic [ADDR_W-1:0] mem_adr_in0_q, mem_adr_in0_d;
  logic [ADDR_W-1:0] mem_adr_out0_q, mem_adr_out0_d;
  logic              mem_can_wrt_q, mem_can_wrt_d;
  logic              mem_can_rd_q, mem_can_rd_d;
`ifdef NR_MAU_WRITE_VERIFY_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  // Next-state and datapath logic. The memory strobes are computed one state
  // ahead so that, once registered, they are high for exactly the cycle spent
  // in WR/RD/VRD and come straight from a flop (the memory gates its clock
  // with them). Address/data buses only change when an access is launched.
  always_comb begin
    state_d        = state_q;
    adr_d          = adr_q;
    data_d         = data_q;
    rsp_data_d     = rsp_data_q;
    mem_in0_d      = mem_in0_q;
    mem_adr_in0_d  = mem_adr_in0_q;
    mem_adr_out0_d = mem_adr_out0_q;
    mem_can_wrt_d  = 1'b0;
    mem_can_rd_d   = 1'b0;
`ifdef NR_MAU_WRITE_VERIFY_EN
    rsp_err_d      = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          adr_d  = req_adr;
          data_d = req_data;
`ifdef NR_MAU_WRITE_VERIFY_EN
          rsp_err_d = 1'b0;
`endif
          if (req_wr) begin
            state_d       = ST_WR;
            mem_adr_in0_d = req_adr;
            mem_in0_d     = req_data;
            mem_can_wrt_d = 1'b1;
          end else begin
            state_d        = ST_RD;
            mem_adr_out0_d = req_adr;
            mem_can_rd_d   = 1'b1;
          end
        end
      end

      ST_WR: begin
        rsp_data_d = data_q;
`ifdef NR_MAU_WRITE_VERIFY_EN
        state_d        = ST_VRD;
        mem_adr_out0_d = adr_q;
        mem_can_rd_d   = 1'b1;
`else
        state_d = ST_RSP;
`endif
      end

      ST_RD: begin
        rsp_data_d = mem_out0;
        state_d    = ST_RSP;
      end

`ifdef NR_MAU_WRITE_VERIFY_EN
      // The memory loaded m_out0 on the negedge of this cycle, so the
      // read-back value is settled by the exiting posedge.
      ST_VRD: begin
        rsp_err_d = (mem_out0 != data_q);
        state_d   = ST_RSP;
      end
`endif

      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset. Reset clears every
  // bus to zero and abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q        <= ST_IDLE;
      adr_q          <= '0;
      data_q         <= '0;
      rsp_data_q     <= '0;
      mem_in0_q      <= '0;
      mem_adr_in0_q  <= '0;
      mem_adr_out0_q <= '0;
      mem_can_wrt_q  <= 1'b0;
      mem_can_rd_q   <= 1'b0;
`ifdef NR_MAU_WRITE_VERIFY_EN
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      adr_q          <= adr_d;
      data_q         <= data_d;
      rsp_data_q     <= rsp_data_d;
      mem_in0_q      <= mem_in0_d;
      mem_adr_in0_q  <= mem_adr_in0_d;
      mem_adr_out0_q <= mem_adr_out0_d;
      mem_can_wrt_q  <= mem_can_wrt_d;
      mem_can_rd_q   <= mem_can_rd_d;
`ifdef NR_MAU_WRITE_VERIFY_EN
      rsp_err_q      <= rsp_err_d;
`endif
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RSP);
  assign rsp_data    = rsp_data_q;
  assign mem_in0     = mem_in0_q;
  assign mem_adrIn0  = mem_adr_in0_q;
  assign mem_adrOut0 = mem_adr_out0_q;
  assign mem_canWrt  = mem_can_wrt_q;
  assign mem_canRd   = mem_can_rd_q;

`ifdef NR_MAU_WRITE_VERIFY_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
